lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// - Load/store unit between the MEM pipeline stage and the byte-enabled, single-port, registered-output data memory.
// - Decodes RV32I load/store funct3, aligns write data and generates byteena, and sequences the memory read latency.
// - Sign-/zero-extends load data and returns one response per accepted request.
// - Flags misaligned, out-of-range and illegal-funct3 accesses without touching memory.
// PARAMETERS
// MEMORY_SIZE   12288                  data memory size in bytes
// ADDR_WIDTH    $clog2(MEMORY_SIZE)    byte-address width
// READ_LATENCY  2                      cycles from the mem_re cycle to valid mem_rdata (addr reg + out reg)
// PORTS
// clk              in   1           system clock, all state on rising edge
// rst              in   1           synchronous reset, active-high
// req_valid        in   1           request present
// req_ready        out  1           unit idle, request accepted when req_valid & req_ready
// req_we           in   1           1 = store, 0 = load
// req_funct3       in   3           RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
// req_addr         in   ADDR_WIDTH  byte address
// req_wdata        in   32          store data, right-justified
// resp_valid       out  1           one-cycle response pulse, no backpressure
// resp_rdata       out  32          extended load data (0 for stores and errors)
// resp_err         out  1           access rejected: misaligned | out-of-range | illegal funct3
// mem_addr         out  ADDR_WIDTH  byte address to data memory (word = mem_addr[13:2])
// mem_we           out  1           memory write strobe
// mem_re           out  1           memory read strobe
// mem_wdata        out  32          lane-replicated write data
// mem_byteena      out  4           byte lane enables
// mem_rdata        in   32          memory read data
// BEHAVIOUR
// - Clock and reset: single clock domain clk; rst is synchronous, active-high.
// - Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0,
//   mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, mem_byteena=0.
// - FSM IDLE -> ISSUE -> (load: WAIT) -> RESP -> IDLE.
//   - IDLE: req_ready=1. On accept in cycle T, latch we, funct3, addr and wdata.
//     - Error requests go straight to RESP.
//   - ISSUE, cycle T+1: mem_* driven from the latched request.
//     - Exactly one of mem_we/mem_re is high, for one cycle only.
//   - WAIT (loads only): down-counter loaded with READ_LATENCY-1.
//     - At 0, capture mem_rdata through the extender into the response register.
//   - RESP: resp_valid=1 for one cycle, then IDLE.
//   - Timing: store response at T+2; load response at T+2+READ_LATENCY (T+4 by default); error response at T+1.
// - Store lanes:
//   - SB: byteena = 4'b0001<<a[1:0], wdata = {4{d[7:0]}}.
//   - SH: byteena = a[1] ? 4'b1100 : 4'b0011, wdata = {2{d[15:0]}}.
//   - SW: byteena = 4'b1111, wdata = d.
// - Load extend: select the byte/half by a[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
// - Errors:
//   - Misaligned: half with a[0]=1, or word with a[1:0]!=0.
//   - Out of range: addr > MEMORY_SIZE-4 for word access, addr >= MEMORY_SIZE otherwise.
//   - Illegal funct3: any other funct3 (e.g. 011, 110, 111, or 100/101 with we=1).
//   - On any error: no mem strobe, resp_err=1, resp_rdata=0.
// - Requests while req_ready=0 are ignored; the upstream stage must hold or stall.
// - resp_valid and req_ready are never high together, so back-to-back throughput is one request per response plus one cycle.
// - Reset mid-operation: an in-flight access is abandoned, no response is issued.
//   - A store already strobed in ISSUE stays committed in memory.
// - mem_addr/mem_wdata/mem_byteena hold their last values outside ISSUE; only the strobes qualify them.
// STRUCTURE
// - Shared package lsu_pkg:
//   - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
//   - FSM state encoding.
// - Sub-module load_extend (combinational):
//   - Inputs mem_rdata, a[1:0], funct3.
//   - Output 32-bit extended data.
//   - Reused by the writeback forwarding path.
// - Everything else (FSM, counter, store lane logic, error check) stays in lsu_mem_ctrl.
// TESTING
// - SB addr 0x0003 data 0x000000AB -> ISSUE at T+1: mem_we=1, byteena=4'b1000, wdata=0xABABABAB; resp_valid at T+2, resp_err=0.
// - SW 0x0010 data 0xDEADBEEF, then LW 0x0010 -> mem_re at T+1, resp_valid at T+4, resp_rdata=0xDEADBEEF.
// - LB 0x0011 / LBU 0x0011 on word 0xDEADBEEF -> 0xFFFFFFBE / 0x000000BE; LH 0x0012 -> 0xFFFFDEAD.
// - LHU 0x0003 -> no mem_we/mem_re; resp_valid at T+1, resp_err=1, resp_rdata=0.
// - LW 0x2FFC ok; LW 0x3000 -> resp_err=1; funct3=3'b011 -> resp_err=1.
// - rst during WAIT -> next cycle IDLE, req_ready=1, no resp_valid; req_valid held during busy -> only first request served.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// funct3 codes and FSM state encoding.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_mem_ctrl_load_extend.sv
// Load data extender: selects byte/half by address and extends it.
// Combinational, shared with the writeback forwarding path.
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  a,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        unique case (a)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = a[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    end

    always_comb begin
        data = mem_rdata;
        case (funct3)
            F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data = {24'h0, byte_sel};
            F3_H:    data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data = {16'h0, half_sel};
            default: data = mem_rdata;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between the MEM stage and a registered-output data memory.
// Checks requests, drives byte lanes, sequences read latency, returns one response.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int MEMORY_SIZE  = 12288,
    parameter int ADDR_WIDTH   = $clog2(MEMORY_SIZE),
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_err,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_byteena,
    input  logic [31:0]           mem_rdata
);

    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);
    localparam logic [31:0] LIM_W   = 32'(MEMORY_SIZE - 4);
    localparam logic [31:0] LIM_ANY = 32'(MEMORY_SIZE);

    lsu_state_t state, state_n;

    logic             we_q;
    logic [2:0]       f3_q;
    logic [CNT_W-1:0] cnt;

    logic        accept;
    logic        f3_legal;
    logic        size_h;
    logic        size_w;
    logic        misal;
    logic        oor;
    logic        acc_err;
    logic [31:0] addr_ext;
    logic [3:0]  be_n;
    logic [31:0] wd_n;
    logic [31:0] ext_data;

    assign accept   = req_valid & req_ready;
    assign addr_ext = 32'(req_addr);

    // funct3 decode; unsigned loads are not valid store encodings
    always_comb begin
        f3_legal = 1'b0;
        size_h   = 1'b0;
        size_w   = 1'b0;
        case (req_funct3)
            F3_B: f3_legal = 1'b1;
            F3_H: begin
                f3_legal = 1'b1;
                size_h   = 1'b1;
            end
            F3_W: begin
                f3_legal = 1'b1;
                size_w   = 1'b1;
            end
            F3_BU: f3_legal = ~req_we;
            F3_HU: begin
                f3_legal = ~req_we;
                size_h   = 1'b1;
            end
            default: f3_legal = 1'b0;
        endcase
    end

    always_comb begin
        misal   = (size_h & req_addr[0])
                | (size_w & (req_addr[1:0] != 2'b00));
        oor     = size_w ? (addr_ext > LIM_W) : (addr_ext >= LIM_ANY);
        acc_err = ~f3_legal | misal | oor;
    end

    always_comb begin
        be_n = 4'b0001 << req_addr[1:0];
        wd_n = {4{req_wdata[7:0]}};
        unique case (1'b1)
            size_w: begin
                be_n = 4'b1111;
                wd_n = req_wdata;
            end
            size_h: begin
                be_n = req_addr[1] ? 4'b1100 : 4'b0011;
                wd_n = {2{req_wdata[15:0]}};
            end
            default: begin
                be_n = 4'b0001 << req_addr[1:0];
                wd_n = {4{req_wdata[7:0]}};
            end
        endcase
    end

    load_extend u_load_extend (
        .mem_rdata (mem_rdata),
        .a         (mem_addr[1:0]),
        .funct3    (f3_q),
        .data      (ext_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = acc_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: state_n = we_q ? ST_RESP : ST_WAIT;
            ST_WAIT:  state_n = (cnt == '0) ? ST_RESP : ST_WAIT;
            ST_RESP:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        mem_we     = (state == ST_ISSUE) & we_q;
        mem_re     = (state == ST_ISSUE) & ~we_q;
    end

    // Memory port registers only move on a clean accept, so errors leave them untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wdata   <= 32'h0;
            mem_byteena <= 4'b0000;
            resp_rdata  <= 32'h0;
            resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                we_q       <= req_we;
                f3_q       <= req_funct3;
                resp_err   <= acc_err;
                resp_rdata <= 32'h0;
                if (!acc_err) begin
                    mem_addr <= req_addr;
                    if (req_we) begin
                        mem_wdata   <= wd_n;
                        mem_byteena <= be_n;
                    end
                end
            end
            if (state == ST_ISSUE) begin
                cnt <= CNT_INIT;
            end
            if (state == ST_WAIT) begin
                if (cnt == '0) begin
                    resp_rdata <= ext_data;
                end else begin
                    cnt <= cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a 2-cycle registered memory model.
// Drives and samples on the falling edge.
module tb_lsu_mem_ctrl;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_byteena;
    logic [31:0]   mem_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:3071];
    logic [11:0] raddr_q;
    logic [31:0] rdata_q;

    always #5 clk = ~clk;

    lsu_mem_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_wdata   (mem_wdata),
        .mem_byteena (mem_byteena),
        .mem_rdata   (mem_rdata)
    );

    // Byte-enabled memory: address register then output register
    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_byteena[b]) begin
                    mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
        raddr_q <= mem_addr[13:2];
        rdata_q <= mem[raddr_q];
    end

    assign mem_rdata = rdata_q;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [13:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd,
                          output logic er, output logic s_we,
                          output logic s_re, output logic [3:0] be,
                          output logic [31:0] wd, output int nstrb);
        @(negedge clk);
        check("ready", 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = d;
        lat   = 0;
        nstrb = 0;
        rd    = 32'h0;
        er    = 1'b0;
        s_we  = 1'b0;
        s_re  = 1'b0;
        be    = 4'h0;
        wd    = 32'h0;
        for (int k = 1; k <= 10 && lat == 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_we || mem_re) nstrb++;
            if (k == 1) begin
                s_we = mem_we;
                s_re = mem_re;
                be   = mem_byteena;
                wd   = mem_wdata;
            end
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
            end
        end
    endtask

    task automatic store_chk(input string tag, input logic [2:0] f3,
                             input logic [13:0] a, input logic [31:0] d,
                             input logic [3:0] ebe, input logic [31:0] ewd);
        int lat, nstrb;
        logic [31:0] rd, wd;
        logic er, swe, sre;
        logic [3:0] be;
        do_req(1'b1, f3, a, d, lat, rd, er, swe, sre, be, wd, nstrb);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_we"}, 32'(swe), 32'd1);
        check({tag, "_be"}, 32'(be), 32'(ebe));
        check({tag, "_wd"}, wd, ewd);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_nstrb"}, 32'(nstrb), 32'd1);
    endtask

    task automatic load_chk(input string tag, input logic [2:0] f3,
                            input logic [13:0] a, input logic [31:0] exp);
        int lat, nstrb;
        logic [31:0] rd, wd;
        logic er, swe, sre;
        logic [3:0] be;
        do_req(1'b0, f3, a, 32'h0, lat, rd, er, swe, sre, be, wd, nstrb);
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_re"}, 32'(sre), 32'd1);
        check({tag, "_data"}, rd, exp);
        check({tag, "_err"}, 32'(er), 32'd0);
        check({tag, "_nstrb"}, 32'(nstrb), 32'd1);
    endtask

    task automatic err_chk(input string tag, input logic we,
                           input logic [2:0] f3, input logic [13:0] a);
        int lat, nstrb;
        logic [31:0] rd, wd;
        logic er, swe, sre;
        logic [3:0] be;
        do_req(we, f3, a, 32'hFFFF_FFFF, lat, rd, er, swe, sre, be, wd, nstrb);
        check({tag, "_lat"}, 32'(lat), 32'd1);
        check({tag, "_err"}, 32'(er), 32'd1);
        check({tag, "_data"}, rd, 32'h0);
        check({tag, "_nstrb"}, 32'(nstrb), 32'd0);
    endtask

    initial begin
        int nresp, nstrb;
        logic [31:0] held_rd;
        for (int i = 0; i < 3072; i++) mem[i] = 32'h0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = '0;
        req_wdata  = 32'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_rvalid", 32'(resp_valid), 32'd0);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_rerr", 32'(resp_err), 32'd0);
        check("rst_mwe", 32'(mem_we), 32'd0);
        check("rst_mre", 32'(mem_re), 32'd0);
        check("rst_maddr", 32'(mem_addr), 32'h0);
        check("rst_mwd", mem_wdata, 32'h0);
        check("rst_mbe", 32'(mem_byteena), 32'h0);

        store_chk("sb3", 3'b000, 14'h0003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
        store_chk("sw10", 3'b010, 14'h0010, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);
        load_chk("lw10", 3'b010, 14'h0010, 32'hDEAD_BEEF);
        load_chk("lb11", 3'b000, 14'h0011, 32'hFFFF_FFBE);
        load_chk("lbu11", 3'b100, 14'h0011, 32'h0000_00BE);
        load_chk("lh12", 3'b001, 14'h0012, 32'hFFFF_DEAD);
        load_chk("lhu12", 3'b101, 14'h0012, 32'h0000_DEAD);
        load_chk("lw0", 3'b010, 14'h0000, 32'hAB00_0000);
        store_chk("sh12", 3'b001, 14'h0012, 32'h5555_1234, 4'b1100, 32'h1234_1234);
        store_chk("sh10", 3'b001, 14'h0010, 32'h0000_8001, 4'b0011, 32'h8001_8001);
        load_chk("lw10b", 3'b010, 14'h0010, 32'h1234_8001);
        load_chk("lh10", 3'b001, 14'h0010, 32'hFFFF_8001);

        err_chk("lhu3", 1'b0, 3'b101, 14'h0003);
        err_chk("lw12", 1'b0, 3'b010, 14'h0012);
        err_chk("sh1", 1'b1, 3'b001, 14'h0001);
        store_chk("sw2ffc", 3'b010, 14'h2FFC, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);
        load_chk("lw2ffc", 3'b010, 14'h2FFC, 32'hCAFE_F00D);
        load_chk("lbu2fff", 3'b100, 14'h2FFF, 32'h0000_00CA);
        err_chk("lw3000", 1'b0, 3'b010, 14'h3000);
        err_chk("lb3000", 1'b0, 3'b000, 14'h3000);
        err_chk("lh3ffe", 1'b0, 3'b001, 14'h3FFE);
        err_chk("f3_011", 1'b0, 3'b011, 14'h0010);
        err_chk("f3_110", 1'b1, 3'b110, 14'h0010);
        err_chk("sbu", 1'b1, 3'b100, 14'h0010);
        load_chk("lw10c", 3'b010, 14'h0010, 32'h1234_8001);

        // reset while the load sits in WAIT
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 14'h0010;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_ready", 32'(req_ready), 32'd1);
        check("rstw_rvalid", 32'(resp_valid), 32'd0);
        rst   = 1'b0;
        nresp = 0;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid) nresp++;
        end
        check("rstw_noresp", 32'(nresp), 32'd0);

        // valid held while busy: only one access and one response
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 14'h0010;
        nresp   = 0;
        nstrb   = 0;
        held_rd = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) check("hold_busy", 32'(req_ready), 32'd0);
            if (k == 4) req_valid = 1'b0;
            if (mem_we || mem_re) nstrb++;
            if (resp_valid) begin
                nresp++;
                held_rd = resp_rdata;
            end
        end
        check("hold_nresp", 32'(nresp), 32'd1);
        check("hold_nstrb", 32'(nstrb), 32'd1);
        check("hold_data", held_rd, 32'h1234_8001);

        store_chk("post_sb", 3'b000, 14'h0021, 32'h0000_0077, 4'b0010, 32'h7777_7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
